// File: rtl/cf_bbox_pos_sched.sv
// Bounding-box position scheduler: shadows tracker updates and commits them to the overlay only at end-of-frame.
// Optional CF_BBOX_CLAMP_EN clamps out-of-range boxes instead of discarding them.
module cf_bbox_pos_sched #(
    parameter int POSITION_WIDTH = 12,
    parameter int FFT_LENGTH     = 64,
    parameter int NPPC           = 4,
    parameter int WIDTH          = 3840,
    parameter int HEIGHT         = 2160,
    parameter int TIMEOUT_FRAMES = 8
) (
    input  logic                          s_axis_video_aclk,
    input  logic                          s_axis_video_aresetn,
    input  logic [2*POSITION_WIDTH-1:0]   POS_IN_tdata,
    input  logic                          POS_IN_tvalid,
    output logic                          POS_IN_tready,
    input  logic                          VID_tvalid,
    input  logic                          VID_tready,
    input  logic                          VID_tuser,
    input  logic                          VID_tlast,
    output logic [POSITION_WIDTH-1:0]     xStart,
    output logic [POSITION_WIDTH-1:0]     yStart,
    output logic                          bbox_en,
    output logic                          pending,
    output logic                          lost,
    output logic [7:0]                    drop_cnt
);

    localparam int PW      = POSITION_WIDTH;
    localparam int LINE_W  = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
    localparam int FRAME_W = $clog2(TIMEOUT_FRAMES + 1);

    localparam logic [LINE_W-1:0]  LAST_LINE    = LINE_W'(HEIGHT - 1);
    localparam logic [FRAME_W-1:0] FRAME_MAX    = FRAME_W'(TIMEOUT_FRAMES);
    localparam logic [PW-1:0]      X_MAX        = PW'(WIDTH - FFT_LENGTH);
    localparam logic [PW-1:0]      Y_MAX        = PW'(HEIGHT - FFT_LENGTH);
    // NPPC is a power of two, so alignment is a mask of the low bits.
    localparam logic [PW-1:0]      X_ALIGN_MASK = ~PW'(NPPC - 1);

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_TRACK = 2'd1,
        ST_LOST  = 2'd2
    } state_t;

    state_t              state_reg;
    state_t              state_next;
    logic                tready_reg;
    logic [PW-1:0]       shadow_x_reg;
    logic [PW-1:0]       shadow_y_reg;
    logic                pending_reg;
    logic [7:0]          drop_cnt_reg;
    logic [PW-1:0]       x_start_reg;
    logic [PW-1:0]       y_start_reg;
    logic [LINE_W-1:0]   line_cnt_reg;
    logic [FRAME_W-1:0]  frame_cnt_reg;
    logic [FRAME_W-1:0]  frame_cnt_next;

    logic [PW-1:0]       pos_x_raw;
    logic [PW-1:0]       pos_y_raw;
    logic [PW-1:0]       pos_x_aligned;
    logic [PW-1:0]       pos_x_cond;
    logic [PW-1:0]       pos_y_cond;
    logic                pos_in_range;
    logic                upd_accept;
    logic                upd_load;
    logic                beat;
    logic                eof;
    logic                commit;
    logic                bbox_en_int;
    logic                lost_int;

    assign pos_x_raw     = POS_IN_tdata[PW-1:0];
    assign pos_y_raw     = POS_IN_tdata[2*PW-1:PW];
    assign pos_x_aligned = pos_x_raw & X_ALIGN_MASK;

`ifdef CF_BBOX_CLAMP_EN
    always_comb begin
        pos_x_cond   = (pos_x_aligned > X_MAX) ? X_MAX : pos_x_aligned;
        pos_y_cond   = (pos_y_raw > Y_MAX) ? Y_MAX : pos_y_raw;
        pos_in_range = 1'b1;
    end
`else
    always_comb begin
        pos_x_cond   = pos_x_aligned;
        pos_y_cond   = pos_y_raw;
        pos_in_range = (pos_x_aligned <= X_MAX) && (pos_y_raw <= Y_MAX);
    end
`endif

    assign upd_accept = POS_IN_tvalid && tready_reg;
    assign upd_load   = upd_accept && pos_in_range;
    assign beat       = VID_tvalid && VID_tready;
    // A start-of-frame beat only resynchronises the line counter, so it can never be an EOF.
    assign eof        = beat && VID_tlast && !VID_tuser && (line_cnt_reg == LAST_LINE);
    assign commit     = eof && pending_reg;

    always_comb begin
        frame_cnt_next = frame_cnt_reg;
        if (commit) begin
            frame_cnt_next = '0;
        end else if (eof && (frame_cnt_reg != FRAME_MAX)) begin
            frame_cnt_next = frame_cnt_reg + 1'b1;
        end
    end

    always_ff @(posedge s_axis_video_aclk or negedge s_axis_video_aresetn) begin
        if (!s_axis_video_aresetn) begin
            tready_reg    <= 1'b0;
            shadow_x_reg  <= '0;
            shadow_y_reg  <= '0;
            pending_reg   <= 1'b0;
            drop_cnt_reg  <= '0;
            x_start_reg   <= '0;
            y_start_reg   <= '0;
            line_cnt_reg  <= '0;
            frame_cnt_reg <= '0;
        end else begin
            tready_reg    <= 1'b1;
            frame_cnt_reg <= frame_cnt_next;

            if (upd_load) begin
                shadow_x_reg <= pos_x_cond;
                shadow_y_reg <= pos_y_cond;
            end

            // An update landing on the commit edge replaces nothing, so it is not a drop.
            if (upd_load) begin
                pending_reg <= 1'b1;
            end else if (commit) begin
                pending_reg <= 1'b0;
            end

            if (upd_load && pending_reg && !commit && (drop_cnt_reg != 8'hFF)) begin
                drop_cnt_reg <= drop_cnt_reg + 8'd1;
            end

            if (commit) begin
                x_start_reg <= shadow_x_reg;
                y_start_reg <= shadow_y_reg;
            end

            if (beat) begin
                if (VID_tuser) begin
                    line_cnt_reg <= '0;
                end else if (VID_tlast) begin
                    line_cnt_reg <= (line_cnt_reg == LAST_LINE) ? '0 : line_cnt_reg + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge s_axis_video_aclk or negedge s_axis_video_aresetn) begin
        if (!s_axis_video_aresetn) begin
            state_reg <= ST_INIT;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_INIT: begin
                if (commit) state_next = ST_TRACK;
            end
            ST_TRACK: begin
                if (!commit && (frame_cnt_next == FRAME_MAX)) state_next = ST_LOST;
            end
            ST_LOST: begin
                if (commit) state_next = ST_TRACK;
            end
            default: state_next = ST_INIT;
        endcase
    end

    always_comb begin
        bbox_en_int = 1'b0;
        lost_int    = 1'b0;
        case (state_reg)
            ST_TRACK: bbox_en_int = 1'b1;
            ST_LOST:  lost_int    = 1'b1;
            default: begin
                bbox_en_int = 1'b0;
                lost_int    = 1'b0;
            end
        endcase
    end

    assign POS_IN_tready = tready_reg;
    assign xStart        = x_start_reg;
    assign yStart        = y_start_reg;
    assign bbox_en       = bbox_en_int;
    assign pending       = pending_reg;
    assign lost          = lost_int;
    assign drop_cnt      = drop_cnt_reg;

endmodule

// File: tb/tb_cf_bbox_pos_sched.sv
// Directed bench for cf_bbox_pos_sched; expected commits are queued when updates are sent and popped at EOF.
module tb_cf_bbox_pos_sched;

    localparam int PW     = 12;
    localparam int HEIGHT = 2160;

    logic          clk;
    logic          rst_n;
    logic [2*PW-1:0] pos_tdata;
    logic          pos_tvalid;
    logic          pos_tready;
    logic          vid_tvalid;
    logic          vid_tready;
    logic          vid_tuser;
    logic          vid_tlast;
    logic [PW-1:0] x_start;
    logic [PW-1:0] y_start;
    logic          bbox_en;
    logic          pending;
    logic          lost;
    logic [7:0]    drop_cnt;

    int tests_run;
    int tests_failed;
    logic [2*PW-1:0] exp_q[$];

    cf_bbox_pos_sched dut (
        .s_axis_video_aclk    (clk),
        .s_axis_video_aresetn (rst_n),
        .POS_IN_tdata         (pos_tdata),
        .POS_IN_tvalid        (pos_tvalid),
        .POS_IN_tready        (pos_tready),
        .VID_tvalid           (vid_tvalid),
        .VID_tready           (vid_tready),
        .VID_tuser            (vid_tuser),
        .VID_tlast            (vid_tlast),
        .xStart               (x_start),
        .yStart               (y_start),
        .bbox_en              (bbox_en),
        .pending              (pending),
        .lost                 (lost),
        .drop_cnt             (drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
        $display("[TB] check %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    task automatic check_commit(input string tag);
        logic [2*PW-1:0] e;
        if (exp_q.size() == 0) begin
            tests_run++;
            tests_failed++;
            $display("FAIL %s: scoreboard empty, observed x=%0d y=%0d", tag, x_start, y_start);
        end else begin
            e = exp_q.pop_front();
            check({tag, "_x"}, 32'(x_start), 32'(e[PW-1:0]));
            check({tag, "_y"}, 32'(y_start), 32'(e[2*PW-1:PW]));
        end
    endtask

    // One cycle with a video beat and optionally a tracker update in the same cycle.
    task automatic cycle(input logic vbeat, input logic user, input logic last,
                         input logic upd, input logic [2*PW-1:0] d);
        @(negedge clk);
        vid_tvalid = vbeat;
        vid_tready = 1'b1;
        vid_tuser  = user;
        vid_tlast  = last;
        pos_tvalid = upd;
        pos_tdata  = d;
        @(posedge clk);
        #1;
        vid_tvalid = 1'b0;
        vid_tuser  = 1'b0;
        vid_tlast  = 1'b0;
        pos_tvalid = 1'b0;
    endtask

    task automatic send_update(input int y, input int x);
        cycle(1'b0, 1'b0, 1'b0, 1'b1, {PW'(y), PW'(x)});
    endtask

    // SOF beat plus HEIGHT-1 line ends: the line counter then sits on the last line.
    task automatic run_pre_eof();
        cycle(1'b1, 1'b1, 1'b0, 1'b0, '0);
        for (int i = 0; i < HEIGHT - 1; i++) cycle(1'b1, 1'b0, 1'b1, 1'b0, '0);
    endtask

    task automatic eof_beat(input logic upd, input logic [2*PW-1:0] d);
        cycle(1'b1, 1'b0, 1'b1, upd, d);
    endtask

    task automatic run_frame();
        run_pre_eof();
        eof_beat(1'b0, '0);
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst_n      = 1'b0;
        pos_tdata  = '0;
        pos_tvalid = 1'b0;
        vid_tvalid = 1'b0;
        vid_tready = 1'b0;
        vid_tuser  = 1'b0;
        vid_tlast  = 1'b0;

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        check("rst_tready", 32'(pos_tready), 0);
        check("rst_x", 32'(x_start), 0);
        check("rst_bbox_en", 32'(bbox_en), 0);
        check("rst_pending", 32'(pending), 0);
        check("rst_lost", 32'(lost), 0);
        check("rst_drop", 32'(drop_cnt), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("tready_after_rst", 32'(pos_tready), 1);

        // Basic commit with x alignment
        send_update(100, 203);
        exp_q.push_back({PW'(100), PW'(200)});
        check("upd1_pending", 32'(pending), 1);
        run_pre_eof();
        check("upd1_x_held", 32'(x_start), 0);
        check("upd1_bbox_init", 32'(bbox_en), 0);
        eof_beat(1'b0, '0);
        check_commit("upd1");
        check("upd1_bbox_en", 32'(bbox_en), 1);
        check("upd1_pending_clr", 32'(pending), 0);

        // Three updates in one frame: last wins, two drops
        send_update(8, 8);
        send_update(16, 16);
        send_update(24, 24);
        exp_q.push_back({PW'(24), PW'(24)});
        check("multi_drop", 32'(drop_cnt), 2);
        run_frame();
        check_commit("multi");

        // Update in the exact EOF cycle
        send_update(40, 40);
        exp_q.push_back({PW'(40), PW'(40)});
        exp_q.push_back({PW'(56), PW'(60)});
        run_pre_eof();
        eof_beat(1'b1, {PW'(56), PW'(60)});
        check_commit("eofupd_first");
        check("eofupd_pending", 32'(pending), 1);
        check("eofupd_drop", 32'(drop_cnt), 2);
        run_frame();
        check_commit("eofupd_second");
        check("eofupd_pending_clr", 32'(pending), 0);

        // Timeout after TIMEOUT_FRAMES frames without commit
        for (int f = 1; f <= 8; f++) begin
            run_frame();
            if (f == 7) begin
                check("to_lost_f7", 32'(lost), 0);
                check("to_bbox_f7", 32'(bbox_en), 1);
            end
        end
        check("to_lost_f8", 32'(lost), 1);
        check("to_bbox_f8", 32'(bbox_en), 0);
        check("to_x_hold", 32'(x_start), 60);
        send_update(100, 100);
        exp_q.push_back({PW'(100), PW'(100)});
        run_frame();
        check_commit("recover");
        check("recover_lost", 32'(lost), 0);
        check("recover_bbox", 32'(bbox_en), 1);

        // Out-of-range update
        send_update(2200, 3900);
`ifdef CF_BBOX_CLAMP_EN
        exp_q.push_back({PW'(2096), PW'(3776)});
        check("range_pending", 32'(pending), 1);
        run_frame();
        check_commit("range_clamp");
`else
        check("range_pending", 32'(pending), 0);
        check("range_drop", 32'(drop_cnt), 2);
        run_frame();
        check("range_x_hold", 32'(x_start), 100);
        check("range_y_hold", 32'(y_start), 100);
`endif

        // Drop counter saturation: first update sets pending, the rest overwrite
        for (int i = 0; i < 260; i++) send_update(200, 200);
        check("drop_sat", 32'(drop_cnt), 255);
        check("sat_pending", 32'(pending), 1);

        // Asynchronous reset mid-frame with pending shadow
        cycle(1'b1, 1'b1, 1'b0, 1'b0, '0);
        for (int i = 0; i < 10; i++) cycle(1'b1, 1'b0, 1'b1, 1'b0, '0);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_x", 32'(x_start), 0);
        check("arst_y", 32'(y_start), 0);
        check("arst_pending", 32'(pending), 0);
        check("arst_bbox", 32'(bbox_en), 0);
        check("arst_lost", 32'(lost), 0);
        check("arst_drop", 32'(drop_cnt), 0);
        check("arst_tready", 32'(pos_tready), 0);
        @(negedge clk);
        rst_n = 1'b1;
        run_frame();
        check("post_rst_x", 32'(x_start), 0);
        check("post_rst_pending", 32'(pending), 0);
        check("post_rst_bbox", 32'(bbox_en), 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
